// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types for the IF-stage fetch controller: FSM states, redirect classes,
// timeout default, and fetch-address alignment.
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_DEBUG  = 2'd2,
        RD_EXC    = 2'd3
    } redir_class_t;

    localparam int FETCH_TIMEOUT_DEFAULT = 16;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_redirect_queue.sv
// Pending redirect store: one flag/target per class, exc > dbg > branch select,
// and clear-on-apply of the applied class plus every lower class it supersedes.
module if_redirect_queue
    import if_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         branch_req,
    input  logic [31:0]  branch_target,
    input  logic         exc_req,
    input  logic [31:0]  exc_target,
    input  logic         dbg_req,
    input  logic [31:0]  dbg_target,
    input  logic         apply,
    output logic         sel_valid,
    output redir_class_t sel_class,
    output logic [31:0]  sel_target
);

    logic        br_pend, exc_pend, dbg_pend;
    logic [31:0] br_tgt, exc_tgt, dbg_tgt;
    logic        br_eff, exc_eff, dbg_eff;
    logic [31:0] br_tgt_eff, exc_tgt_eff, dbg_tgt_eff;

    // A request arriving this cycle already takes part in selection and overrides its stored target.
    always_comb begin
        br_eff      = br_pend  | branch_req;
        exc_eff     = exc_pend | exc_req;
        dbg_eff     = dbg_pend | dbg_req;
        br_tgt_eff  = branch_req ? branch_target : br_tgt;
        exc_tgt_eff = exc_req    ? exc_target    : exc_tgt;
        dbg_tgt_eff = dbg_req    ? dbg_target    : dbg_tgt;

        sel_valid  = exc_eff | dbg_eff | br_eff;
        sel_class  = RD_NONE;
        sel_target = '0;
        if (exc_eff) begin
            sel_class  = RD_EXC;
            sel_target = exc_tgt_eff;
        end else if (dbg_eff) begin
            sel_class  = RD_DEBUG;
            sel_target = dbg_tgt_eff;
        end else if (br_eff) begin
            sel_class  = RD_BRANCH;
            sel_target = br_tgt_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_pend  <= 1'b0;
            exc_pend <= 1'b0;
            dbg_pend <= 1'b0;
            br_tgt   <= '0;
            exc_tgt  <= '0;
            dbg_tgt  <= '0;
        end else begin
            // Branch is the lowest class, so any applied redirect retires it.
            exc_pend <= exc_eff & ~(apply && sel_class == RD_EXC);
            dbg_pend <= dbg_eff & ~(apply && (sel_class == RD_EXC || sel_class == RD_DEBUG));
            br_pend  <= br_eff  & ~apply;
            br_tgt   <= br_tgt_eff;
            exc_tgt  <= exc_tgt_eff;
            dbg_tgt  <= dbg_tgt_eff;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: FSM, instruction latch and redirect application.
// Optional fetch timeout is enabled by defining IF_FETCH_TIMEOUT_EN.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
`ifdef IF_FETCH_TIMEOUT_EN
#(
    parameter int FETCH_TIMEOUT_CYCLES = FETCH_TIMEOUT_DEFAULT
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_address,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    input  logic [31:0] exc_target,
    input  logic        dbg_req,
    input  logic [31:0] dbg_target,
    output logic        pc_enable,
    output logic        do_branch,
    output logic [31:0] branch_address,
    output logic        do_exception,
    output logic [31:0] exception_address,
    output logic        do_debug,
    output logic [31:0] debug_address,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        id_ready,
    output logic        fetch_fault
);

    fetch_state_t state_q, state_d;
    logic         apply, handshake, latch, timeout;
    logic         sel_valid;
    redir_class_t sel_class;
    logic [31:0]  sel_target;

    if_redirect_queue u_redirect_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .exc_req       (exc_req),
        .exc_target    (exc_target),
        .dbg_req       (dbg_req),
        .dbg_target    (dbg_target),
        .apply         (apply),
        .sel_valid     (sel_valid),
        .sel_class     (sel_class),
        .sel_target    (sel_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirects are only applied on a fetch ack or while holding an instruction, never mid-request.
    always_comb begin
        state_d   = state_q;
        apply     = 1'b0;
        handshake = 1'b0;
        latch     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (ibus_ack) begin
                    apply   = sel_valid;
                    latch   = ~sel_valid;
                    state_d = sel_valid ? ST_FETCH : ST_HOLD;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (sel_valid) begin
                    apply   = 1'b1;
                    state_d = ST_FETCH;
                end else if (id_ready) begin
                    handshake = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_data <= '0;
            inst_pc   <= '0;
        end else if (latch) begin
            inst_data <= ibus_rdata;
            inst_pc   <= pc_address;
        end
    end

    assign do_exception      = apply && sel_class == RD_EXC;
    assign do_debug          = apply && sel_class == RD_DEBUG;
    assign do_branch         = apply && sel_class == RD_BRANCH;
    assign pc_enable         = handshake | do_branch;
    assign exception_address = do_exception ? sel_target : '0;
    assign debug_address     = do_debug     ? sel_target : '0;
    assign branch_address    = do_branch    ? sel_target : '0;

    assign ibus_req   = (state_q == ST_FETCH);
    assign ibus_addr  = ibus_req ? word_align(pc_address) : '0;
    assign inst_valid = (state_q == ST_HOLD) && !sel_valid;

`ifdef IF_FETCH_TIMEOUT_EN
    logic [7:0] timeout_cnt;

    // Any cycle outside FETCH, or an ack, restarts the count for the next fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
        end else if (state_q != ST_FETCH || ibus_ack) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    assign timeout     = (state_q == ST_FETCH) && !ibus_ack &&
                         (timeout_cnt == 8'(FETCH_TIMEOUT_CYCLES - 1));
    assign fetch_fault = timeout;
`else
    assign timeout     = 1'b0;
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl with a simple PC block and scripted bus responder.
// The timeout scenario runs when IF_FETCH_TIMEOUT_EN is defined; otherwise an endless stall is checked.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_address;
    logic        branch_req = 1'b0, exc_req = 1'b0, dbg_req = 1'b0;
    logic [31:0] branch_target = '0, exc_target = '0, dbg_target = '0;
    logic        pc_enable, do_branch, do_exception, do_debug;
    logic [31:0] branch_address, exception_address, debug_address;
    logic        ibus_req, ibus_ack = 1'b0;
    logic [31:0] ibus_addr, ibus_rdata = '0;
    logic        inst_valid, id_ready = 1'b0, fetch_fault;
    logic [31:0] inst_data, inst_pc;

    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];

    if_fetch_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_address        (pc_address),
        .branch_req        (branch_req),
        .branch_target     (branch_target),
        .exc_req           (exc_req),
        .exc_target        (exc_target),
        .dbg_req           (dbg_req),
        .dbg_target        (dbg_target),
        .pc_enable         (pc_enable),
        .do_branch         (do_branch),
        .branch_address    (branch_address),
        .do_exception      (do_exception),
        .exception_address (exception_address),
        .do_debug          (do_debug),
        .debug_address     (debug_address),
        .ibus_req          (ibus_req),
        .ibus_addr         (ibus_addr),
        .ibus_ack          (ibus_ack),
        .ibus_rdata        (ibus_rdata),
        .inst_valid        (inst_valid),
        .inst_data         (inst_data),
        .inst_pc           (inst_pc),
        .id_ready          (id_ready),
        .fetch_fault       (fetch_fault)
    );

    always #5 clk = ~clk;

    // PC block model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pc_address <= 32'hbfc0_0000;
        else if (do_exception) pc_address <= exception_address;
        else if (do_debug)     pc_address <= debug_address;
        else if (pc_enable)    pc_address <= do_branch ? branch_address : pc_address + 32'd4;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0f0f_f0f0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on every ID handshake
    always @(negedge clk) begin
        #2;
        if (rst_n && inst_valid && id_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_inst", inst_pc, 32'hffff_ffff);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("sb_inst_pc", inst_pc, e[63:32]);
                check("sb_inst_data", inst_data, e[31:0]);
            end
        end
    end

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (ibus_req !== 1'b1 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_req"}, ibus_req, 1);
        check({tag, "_addr"}, ibus_addr, exp_addr);
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input int gap, input bit push);
        wait_req(tag, exp_addr);
        repeat (gap - 1) @(negedge clk);
        @(negedge clk);
        ibus_ack   = 1'b1;
        ibus_rdata = mem(exp_addr);
        if (push) sb.push_back({exp_addr, mem(exp_addr)});
        #1;
        check({tag, "_ack_nvalid"}, inst_valid, 0);
    endtask

    task automatic ack_off();
        @(negedge clk);
        ibus_ack   = 1'b0;
        ibus_rdata = '0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ibus_req", ibus_req, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_pc_enable", pc_enable, 0);
        check("rst_do_any", {do_branch, do_exception, do_debug, fetch_fault}, 0);
        check("rst_inst_data", inst_data, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        id_ready = 1'b1;
        #1;

        // 1: plain fetch and ID handshake
        do_fetch("t1", 32'hbfc0_0000, 2, 1'b1);
        ack_off();
        check("t1_valid", inst_valid, 1);
        check("t1_pc_enable", pc_enable, 1);
        check("t1_no_branch", do_branch, 0);

        // 2: branch during FETCH is held until the ack
        wait_req("t2", 32'hbfc0_0004);
        @(negedge clk);
        branch_req = 1'b1; branch_target = 32'h8000_1000;
        #1;
        check("t2_branch_early", do_branch, 0);
        @(negedge clk);
        branch_req = 1'b0;
        @(negedge clk);
        ibus_ack = 1'b1; ibus_rdata = mem(32'hbfc0_0004);
        #1;
        check("t2_do_branch", do_branch, 1);
        check("t2_pc_enable", pc_enable, 1);
        check("t2_branch_addr", branch_address, 32'h8000_1000);
        check("t2_ack_nvalid", inst_valid, 0);
        ack_off();
        check("t2_drop_valid", inst_valid, 0);
        check("t2_redir_req", ibus_req, 1);
        check("t2_redir_addr", ibus_addr, 32'h8000_1000);

        // 3: exception and branch in the ack cycle
        @(negedge clk);
        exc_req = 1'b1; exc_target = 32'h8000_0180;
        branch_req = 1'b1; branch_target = 32'h8000_2000;
        ibus_ack = 1'b1; ibus_rdata = mem(32'h8000_1000);
        #1;
        check("t3_do_exc", do_exception, 1);
        check("t3_exc_addr", exception_address, 32'h8000_0180);
        check("t3_no_branch", do_branch, 0);
        check("t3_pc_enable", pc_enable, 0);
        @(negedge clk);
        exc_req = 1'b0; branch_req = 1'b0; ibus_ack = 1'b0; ibus_rdata = '0;
        #1;
        check("t3_redir_addr", ibus_addr, 32'h8000_0180);
        do_fetch("t3b", 32'h8000_0180, 1, 1'b1);
        check("t3b_no_branch", do_branch, 0);
        ack_off();
        check("t3b_pc_enable", pc_enable, 1);
        check("t3b_no_branch2", do_branch, 0);
        @(negedge clk);
        id_ready = 1'b0;
        #1;

        // 4: stalled HOLD then debug redirect; stray ack ignored
        do_fetch("t4", 32'h8000_0184, 1, 1'b0);
        ack_off();
        check("t4_valid", inst_valid, 1);
        check("t4_inst_pc", inst_pc, 32'h8000_0184);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ibus_ack   = (i == 2);
            ibus_rdata = (i == 2) ? 32'hdead_beef : 32'h0;
            #1;
            check("t4_hold_valid", inst_valid, 1);
            check("t4_hold_pcen", pc_enable, 0);
        end
        check("t4_stray_ack", inst_data, mem(32'h8000_0184));
        @(negedge clk);
        ibus_ack = 1'b0; ibus_rdata = '0;
        dbg_req = 1'b1; dbg_target = 32'hbfc0_0100; id_ready = 1'b1;
        #1;
        check("t4_valid_fall", inst_valid, 0);
        check("t4_do_debug", do_debug, 1);
        check("t4_dbg_addr", debug_address, 32'hbfc0_0100);
        check("t4_pc_enable", pc_enable, 0);
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        do_fetch("t4b", 32'hbfc0_0100, 1, 1'b1);
        ack_off();
        check("t4b_pc_enable", pc_enable, 1);

        // 6: reset mid-fetch with a pending branch
        wait_req("t6", 32'hbfc0_0104);
        @(negedge clk);
        branch_req = 1'b1; branch_target = 32'h9000_0000;
        @(negedge clk);
        branch_req = 1'b0; rst_n = 1'b0;
        #1;
        check("t6_rst_req", ibus_req, 0);
        check("t6_rst_outs", {pc_enable, do_branch, do_exception, do_debug, inst_valid, fetch_fault}, 0);
        check("t6_rst_inst_pc", inst_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        do_fetch("t6b", 32'hbfc0_0000, 1, 1'b1);
        check("t6b_no_branch", do_branch, 0);
        ack_off();
        check("t6b_valid", inst_valid, 1);

`ifdef IF_FETCH_TIMEOUT_EN
        // 5: timeout pulse on the 16th unacknowledged FETCH cycle
        wait_req("t5", 32'hbfc0_0004);
        for (int i = 1; i < 16; i++) begin
            check("t5_fault_quiet", fetch_fault, 0);
            @(negedge clk); #1;
        end
        check("t5_fault_pulse", fetch_fault, 1);
        @(negedge clk); #1;
        check("t5_req_drop", ibus_req, 0);
        check("t5_fault_end", fetch_fault, 0);
`else
        // 5: without the timeout, FETCH waits indefinitely
        wait_req("t5", 32'hbfc0_0004);
        repeat (20) begin
            @(negedge clk); #1;
        end
        check("t5_no_fault", fetch_fault, 0);
        check("t5_still_req", ibus_req, 1);
`endif
        do_fetch("t7", 32'hbfc0_0004, 1, 1'b1);
        ack_off();
        check("t7_valid", inst_valid, 1);
        repeat (3) @(negedge clk);
        #3;
        check("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
